// File: rtl/dcache_store_port_pkg.sv
// ---------------------------------------------------------------------------
// dcache_store_port_pkg
// Shared constants and types for the data-cache store port.
//   - `define constants for the memory access type (MAT) codes and the FSM
//     state encodings; they are visible to every file compiled after this one.
//   - Package dcache_store_port_pkg: state enum built from those encodings,
//     the request payload struct and a MAT decode helper.
// ---------------------------------------------------------------------------
`ifndef DCACHE_STORE_PORT_DEFS
`define DCACHE_STORE_PORT_DEFS
`define DCD_MAT_CACHED      2'b01
`define DCD_MAT_UNCACHED    2'b00
`define DCD_ST_IDLE         3'd0
`define DCD_ST_LOOKUP       3'd1
`define DCD_ST_CHECK        3'd2
`define DCD_ST_WRITE        3'd3
`define DCD_ST_BUSREQ       3'd4
`define DCD_ST_BUSWAIT      3'd5
`define DCD_ST_RESP         3'd6
`endif

package dcache_store_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = `DCD_ST_IDLE,
    ST_LOOKUP  = `DCD_ST_LOOKUP,
    ST_CHECK   = `DCD_ST_CHECK,
    ST_WRITE   = `DCD_ST_WRITE,
    ST_BUSREQ  = `DCD_ST_BUSREQ,
    ST_BUSWAIT = `DCD_ST_BUSWAIT,
    ST_RESP    = `DCD_ST_RESP
  } dcd_state_e;

  localparam logic [1:0] MAT_CACHED = `DCD_MAT_CACHED;

  // One retired store: 3 + 2 + 32 + 32 = 69 bits.
  typedef struct packed {
    logic [2:0]  ptr;
    logic [1:0]  mat;
    logic [31:0] addr;
    logic [31:0] data;
  } st_req_t;

  // Only the exact cached code goes through the cache; everything else is
  // treated as uncached.
  function automatic logic is_cached(input logic [1:0] mat);
    return (mat == MAT_CACHED);
  endfunction

endpackage

// File: rtl/dcache_store_port_if.sv
// ---------------------------------------------------------------------------
// dcache_store_port_if
// Bundles the store-buffer request/response, cache tag/data strobes and the
// bus write handshake of the store port.
//   slave  : the store port itself (dcache_store_port)
//   master : the surrounding store buffer / cache arrays / bus
// ---------------------------------------------------------------------------
interface dcache_store_port_if;

  // store buffer -> store port
  logic        SbToDcdAble;
  logic [1:0]  SbToDcdAMat;
  logic [2:0]  SbToDcdAPtr;
  logic [31:0] SbToDcdAPhyAddr;
  logic [31:0] SbToDcdAPhyDate;
  // store port -> store buffer
  logic        DcdToSbSuccess;
  logic        DcdToSbBackAble;
  logic [2:0]  DcdToSbBackPtr;
  // shared address/data for cache and bus
  logic [31:0] StAddr;
  logic [31:0] StDate;
  // cache arrays
  logic        TagRdAble;
  logic        TagRdHit;
  logic        DataWrAble;
  // bus write channel
  logic        BusWrValid;
  logic        BusWrReady;
  logic        BusWrBack;

  modport slave (
    input  SbToDcdAble, SbToDcdAMat, SbToDcdAPtr, SbToDcdAPhyAddr, SbToDcdAPhyDate,
    input  TagRdHit, BusWrReady, BusWrBack,
    output DcdToSbSuccess, DcdToSbBackAble, DcdToSbBackPtr,
    output StAddr, StDate, TagRdAble, DataWrAble, BusWrValid
  );

  modport master (
    output SbToDcdAble, SbToDcdAMat, SbToDcdAPtr, SbToDcdAPhyAddr, SbToDcdAPhyDate,
    output TagRdHit, BusWrReady, BusWrBack,
    input  DcdToSbSuccess, DcdToSbBackAble, DcdToSbBackPtr,
    input  StAddr, StDate, TagRdAble, DataWrAble, BusWrValid
  );

endinterface

// File: rtl/dcache_store_port_store_req_queue.sv
// ---------------------------------------------------------------------------
// store_req_queue
// Two-entry FIFO of store requests (69-bit st_req_t payload) placed in front
// of the store-port FSM. Only built when DCD_STORE_ACCEPT_Q_EN is defined.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write push_data_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   pop_data_o   : head entry
//   full_o       : both entries occupied
//   empty_o      : no entry occupied
// A push and a pop in the same cycle are both performed.
// ---------------------------------------------------------------------------
`ifdef DCD_STORE_ACCEPT_Q_EN
module store_req_queue
  import dcache_store_port_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  st_req_t push_data_i,
  input  logic    pop_i,
  output st_req_t pop_data_o,
  output logic    full_o,
  output logic    empty_o
);

  st_req_t    mem_q [2];
  st_req_t    mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q,  count_d;
  logic       do_push_s;
  logic       do_pop_s;

  assign full_o     = (count_q == 2'd2);
  assign empty_o    = (count_q == 2'd0);
  assign do_push_s  = push_i & ~full_o;
  assign do_pop_s   = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
  end

  // Queue state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`endif

// File: rtl/dcache_store_port.sv
// ---------------------------------------------------------------------------
// dcache_store_port
// Takes retired stores from the store buffer one at a time. Cached stores
// (MAT 2'b01) look up the tag and write the data array on a hit; misses
// (write-around, no allocate) and uncached stores go out as a bus write.
// Each accepted store produces exactly one DcdToSbBackAble pulse, in order.
//
// Ports:
//   Clk   : clock, rising edge
//   Rest  : asynchronous active-high reset; drops any in-flight store
//   sp    : dcache_store_port_if.slave -- store buffer request/response,
//           StAddr/StDate, tag/data strobes, bus write handshake
//
// Build option:
//   DCD_STORE_ACCEPT_Q_EN : insert a 2-entry request queue (store_req_queue);
//                           the store buffer is then accepted in any state
//                           while the queue has room, and the FSM pops it in
//                           IDLE. Undefined: accept only in IDLE.
// ---------------------------------------------------------------------------
module dcache_store_port
  import dcache_store_port_pkg::*;
(
  input  logic               Clk,
  input  logic               Rest,
  dcache_store_port_if.slave sp
);

  dcd_state_e  state_q,      state_d;
  logic [2:0]  ptr_q,        ptr_d;
  logic [1:0]  mat_q,        mat_d;
  logic [31:0] st_addr_q,    st_addr_d;
  logic [31:0] st_data_q,    st_data_d;
  logic        tag_rd_q,     tag_rd_d;
  logic        data_wr_q,    data_wr_d;
  logic        bus_valid_q,  bus_valid_d;
  logic        back_able_q,  back_able_d;
  logic [2:0]  back_ptr_q,   back_ptr_d;

  st_req_t     in_req_s;     // request as presented by the store buffer
  st_req_t     req_s;        // request seen by the FSM
  logic        req_valid_s;
  logic        req_take_s;   // FSM consumes req_s this cycle

  assign in_req_s   = {sp.SbToDcdAPtr, sp.SbToDcdAMat,
                       sp.SbToDcdAPhyAddr, sp.SbToDcdAPhyDate};
  assign req_take_s = req_valid_s & (state_q == ST_IDLE);

`ifdef DCD_STORE_ACCEPT_Q_EN
  logic q_full_s;
  logic q_empty_s;
  logic push_s;

  // Rest gates the accept so the store buffer never sees Success during reset.
  assign push_s            = sp.SbToDcdAble & ~q_full_s & ~Rest;
  assign sp.DcdToSbSuccess = push_s;
  assign req_valid_s       = ~q_empty_s;

  store_req_queue u_store_req_queue (
    .clk         (Clk),
    .rst         (Rest),
    .push_i      (push_s),
    .push_data_i (in_req_s),
    .pop_i       (req_take_s),
    .pop_data_o  (req_s),
    .full_o      (q_full_s),
    .empty_o     (q_empty_s)
  );
`else
  assign req_valid_s       = sp.SbToDcdAble & ~Rest;
  assign req_s             = in_req_s;
  assign sp.DcdToSbSuccess = req_take_s;
`endif

  // FSM next-state and next-cycle output strobes. Strobes are computed for
  // the state being entered so that every output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mat_d       = mat_q;
    st_addr_d   = st_addr_q;
    st_data_d   = st_data_q;
    tag_rd_d    = 1'b0;
    data_wr_d   = 1'b0;
    bus_valid_d = 1'b0;
    back_able_d = 1'b0;
    back_ptr_d  = 3'd0;
    case (state_q)
      ST_IDLE: begin
        if (req_take_s) begin
          ptr_d     = req_s.ptr;
          mat_d     = req_s.mat;
          st_addr_d = req_s.addr;
          st_data_d = req_s.data;
          if (is_cached(req_s.mat)) begin
            state_d  = ST_LOOKUP;
            tag_rd_d = 1'b1;
          end else begin
            state_d     = ST_BUSREQ;
            bus_valid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // The MAT re-check keeps a corrupted path from writing the array for
        // a store that was never meant to be cached.
        if (sp.TagRdHit && is_cached(mat_q)) begin
          state_d     = ST_WRITE;
          data_wr_d   = 1'b1;
          back_able_d = 1'b1;
          back_ptr_d  = ptr_q;
        end else begin
          state_d     = ST_BUSREQ;
          bus_valid_d = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_BUSREQ: begin
        // A response is only meaningful once the write has been accepted,
        // so BusWrBack without BusWrReady is ignored here.
        if (sp.BusWrReady) begin
          if (sp.BusWrBack) begin
            state_d     = ST_RESP;
            back_able_d = 1'b1;
            back_ptr_d  = ptr_q;
          end else begin
            state_d = ST_BUSWAIT;
          end
        end else begin
          bus_valid_d = 1'b1;
        end
      end
      ST_BUSWAIT: begin
        if (sp.BusWrBack) begin
          state_d     = ST_RESP;
          back_able_d = 1'b1;
          back_ptr_d  = ptr_q;
        end else begin
          state_d = ST_BUSWAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, latched store fields and registered outputs.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 3'd0;
      mat_q       <= 2'd0;
      st_addr_q   <= 32'd0;
      st_data_q   <= 32'd0;
      tag_rd_q    <= 1'b0;
      data_wr_q   <= 1'b0;
      bus_valid_q <= 1'b0;
      back_able_q <= 1'b0;
      back_ptr_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mat_q       <= mat_d;
      st_addr_q   <= st_addr_d;
      st_data_q   <= st_data_d;
      tag_rd_q    <= tag_rd_d;
      data_wr_q   <= data_wr_d;
      bus_valid_q <= bus_valid_d;
      back_able_q <= back_able_d;
      back_ptr_q  <= back_ptr_d;
    end
  end

  assign sp.DcdToSbBackAble = back_able_q;
  assign sp.DcdToSbBackPtr  = back_ptr_q;
  assign sp.StAddr          = st_addr_q;
  assign sp.StDate          = st_data_q;
  assign sp.TagRdAble       = tag_rd_q;
  assign sp.DataWrAble      = data_wr_q;
  assign sp.BusWrValid      = bus_valid_q;

endmodule

// File: tb/tb_dcache_store_port.sv
// ---------------------------------------------------------------------------
// tb_dcache_store_port
// Directed vectors drive the store buffer, tag-hit and bus handshake per
// cycle; the expected completion (tag and cycle) is queued when a store is
// issued, and a monitor compares every DcdToSbBackAble pulse against it.
// ---------------------------------------------------------------------------
module tb_dcache_store_port;

  logic Clk;
  logic Rest;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  typedef struct {
    logic [2:0] ptr;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  dcache_store_port_if sif ();

  dcache_store_port dut (
    .Clk  (Clk),
    .Rest (Rest),
    .sp   (sif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Completion monitor: every BackAble pulse must match the oldest expected one.
  always @(negedge Clk) begin
    exp_t e;
    if (sif.DcdToSbBackAble === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("back_unexpected", {31'd0, sif.DcdToSbBackAble}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("back_ptr", {29'd0, sif.DcdToSbBackPtr}, {29'd0, e.ptr});
        chk("back_cycle", cyc, e.cyc);
      end
    end else begin
      chk("back_ptr_idle", {29'd0, sif.DcdToSbBackPtr}, 32'd0);
    end
  end

  // Bit k of each vector applies to cycle T+k, T being the first cycle.
  task automatic run_vec(
    input string       nm,
    input logic [2:0]  p1, input logic [1:0] m1, input logic [31:0] a1, input logic [31:0] d1,
    input logic [2:0]  p2, input logic [1:0] m2, input logic [31:0] a2, input logic [31:0] d2,
    input logic [15:0] able_v, input logic [15:0] hit_v,
    input logic [15:0] rdy_v,  input logic [15:0] back_v,
    input logic [15:0] succ_v, input logic [15:0] tag_v,
    input logic [15:0] dwr_v,  input logic [15:0] bv_v,
    input int          n,      input bit chk_st
  );
    for (int k = 0; k < n; k++) begin
      sif.SbToDcdAble     = able_v[k];
      sif.SbToDcdAPtr     = (k == 0) ? p1 : p2;
      sif.SbToDcdAMat     = (k == 0) ? m1 : m2;
      sif.SbToDcdAPhyAddr = (k == 0) ? a1 : a2;
      sif.SbToDcdAPhyDate = (k == 0) ? d1 : d2;
      sif.TagRdHit        = hit_v[k];
      sif.BusWrReady      = rdy_v[k];
      sif.BusWrBack       = back_v[k];
      @(negedge Clk);
      chk($sformatf("%s_k%0d_success", nm, k), {31'd0, sif.DcdToSbSuccess}, {31'd0, succ_v[k]});
      chk($sformatf("%s_k%0d_tagrd", nm, k),   {31'd0, sif.TagRdAble},      {31'd0, tag_v[k]});
      chk($sformatf("%s_k%0d_datawr", nm, k),  {31'd0, sif.DataWrAble},     {31'd0, dwr_v[k]});
      chk($sformatf("%s_k%0d_buswr", nm, k),   {31'd0, sif.BusWrValid},     {31'd0, bv_v[k]});
      if (chk_st && k >= 1) begin
        chk($sformatf("%s_k%0d_staddr", nm, k), sif.StAddr, a1);
        chk($sformatf("%s_k%0d_stdate", nm, k), sif.StDate, d1);
      end
      @(posedge Clk);
      #1;
    end
    sif.SbToDcdAble = 1'b0;
    sif.TagRdHit    = 1'b0;
    sif.BusWrReady  = 1'b0;
    sif.BusWrBack   = 1'b0;
  endtask

  task automatic push_exp(input logic [2:0] p, input int at);
    exp_t e;
    e.ptr = p;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc    = 0;
    n_cmp  = 0;
    n_fail = 0;
    Rest   = 1'b1;
    sif.SbToDcdAble     = 1'b1;
    sif.SbToDcdAMat     = 2'b01;
    sif.SbToDcdAPtr     = 3'd1;
    sif.SbToDcdAPhyAddr = 32'd0;
    sif.SbToDcdAPhyDate = 32'd0;
    sif.TagRdHit        = 1'b0;
    sif.BusWrReady      = 1'b0;
    sif.BusWrBack       = 1'b0;

    // Reset state, with a request already presented.
    repeat (3) @(posedge Clk);
    #2;
    chk("rst_success", {31'd0, sif.DcdToSbSuccess}, 32'd0);
    chk("rst_backable", {31'd0, sif.DcdToSbBackAble}, 32'd0);
    chk("rst_staddr", sif.StAddr, 32'd0);
    chk("rst_stdate", sif.StDate, 32'd0);
    chk("rst_tagrd", {31'd0, sif.TagRdAble}, 32'd0);
    chk("rst_datawr", {31'd0, sif.DataWrAble}, 32'd0);
    chk("rst_buswr", {31'd0, sif.BusWrValid}, 32'd0);
    sif.SbToDcdAble = 1'b0;
    @(posedge Clk);
    #1;
    Rest = 1'b0;
    @(posedge Clk);
    #1;

    // Cached hit; stray TagRdHit in LOOKUP and stray BusWrBack in IDLE.
    push_exp(3'd3, cyc + 3);
    run_vec("hit", 3'd3, 2'b01, 32'h0000_1000, 32'hDEAD_BEEF,
            3'd3, 2'b01, 32'h0000_1000, 32'hDEAD_BEEF,
            16'h0001, 16'h0006, 16'h0000, 16'h0010,
            16'h0001, 16'h0002, 16'h0008, 16'h0000, 6, 1'b1);

    // Cached miss -> write-around; stray hits outside CHECK, stray back in LOOKUP.
    push_exp(3'd5, cyc + 8);
    run_vec("miss", 3'd5, 2'b01, 32'h2000_0040, 32'h1234_5678,
            3'd5, 2'b01, 32'h2000_0040, 32'h1234_5678,
            16'h0001, 16'h000A, 16'h0020, 16'h0082,
            16'h0001, 16'h0002, 16'h0000, 16'h0038, 10, 1'b1);

    // Uncached MAT 00: ready at first request cycle, response one cycle later.
    push_exp(3'd7, cyc + 3);
    run_vec("unc00", 3'd7, 2'b00, 32'h8000_0000, 32'hCAFE_F00D,
            3'd7, 2'b00, 32'h8000_0000, 32'hCAFE_F00D,
            16'h0001, 16'h0000, 16'h0002, 16'h0004,
            16'h0001, 16'h0000, 16'h0000, 16'h0002, 5, 1'b1);

    // Uncached MAT 10: ready delayed one cycle, response with ready.
    push_exp(3'd4, cyc + 3);
    run_vec("unc10", 3'd4, 2'b10, 32'h4000_0100, 32'h0BAD_F00D,
            3'd4, 2'b10, 32'h4000_0100, 32'h0BAD_F00D,
            16'h0001, 16'h0000, 16'h0004, 16'h0004,
            16'h0001, 16'h0000, 16'h0000, 16'h0006, 5, 1'b1);

    // Back-to-back: Ptr1 uncached then Ptr2 cached hit, Able held high.
    push_exp(3'd1, cyc + 3);
    push_exp(3'd2, cyc + 7);
    run_vec("b2b", 3'd1, 2'b00, 32'h0000_0010, 32'h1111_1111,
            3'd2, 2'b01, 32'h0000_0020, 32'h2222_2222,
            16'h001F, 16'h0040, 16'h0002, 16'h0004,
            16'h0011, 16'h0020, 16'h0080, 16'h0002, 9, 1'b0);
    chk("b2b_staddr", sif.StAddr, 32'h0000_0020);
    chk("b2b_stdate", sif.StDate, 32'h2222_2222);

    // Reset while in BUSWAIT: store dropped, outputs cleared at once.
    run_vec("rstbw", 3'd6, 2'b00, 32'h0000_0600, 32'h6666_6666,
            3'd6, 2'b00, 32'h0000_0600, 32'h6666_6666,
            16'h0001, 16'h0000, 16'h0002, 16'h0000,
            16'h0001, 16'h0000, 16'h0000, 16'h0002, 3, 1'b1);
    Rest = 1'b1;
    sif.SbToDcdAble = 1'b1;
    #2;
    chk("rstbw_success", {31'd0, sif.DcdToSbSuccess}, 32'd0);
    chk("rstbw_buswr", {31'd0, sif.BusWrValid}, 32'd0);
    chk("rstbw_backable", {31'd0, sif.DcdToSbBackAble}, 32'd0);
    chk("rstbw_staddr", sif.StAddr, 32'd0);
    chk("rstbw_stdate", sif.StDate, 32'd0);
    sif.SbToDcdAble = 1'b0;
    @(posedge Clk);
    #1;
    Rest          = 1'b0;
    sif.BusWrBack = 1'b1;
    @(negedge Clk);
    chk("rstbw_late_buswr", {31'd0, sif.BusWrValid}, 32'd0);
    @(posedge Clk);
    #1;
    sif.BusWrBack = 1'b0;
    @(posedge Clk);
    #1;

    // FSM back in IDLE after reset: a fresh hit completes normally.
    push_exp(3'd1, cyc + 3);
    run_vec("post", 3'd1, 2'b01, 32'h0000_0F00, 32'hA5A5_5A5A,
            3'd1, 2'b01, 32'h0000_0F00, 32'hA5A5_5A5A,
            16'h0001, 16'h0004, 16'h0000, 16'h0000,
            16'h0001, 16'h0002, 16'h0008, 16'h0000, 6, 1'b1);

    repeat (3) @(posedge Clk);
    #1;
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
